// File: rtl/bp_pkg.sv
// Shared definitions for the tournament branch predictor.
//   bp_state_e       : table-init FSM states (INIT sweep, RUN)
//   max()            : integer maximum, used to size the init sweep pointer
//   sat_inc/sat_dec  : width-generic saturating counter helpers. Callers widen
//                      the value to 32 bits and truncate the result back.
package bp_pkg;

  typedef enum logic {INIT, RUN} bp_state_e;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Increment, holding at 2^w-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (32'd1 << w) - 32'd1;
    return (v >= top) ? top : v + 32'd1;
  endfunction

  // Decrement, holding at 0.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == '0) ? '0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/tournament_predictor_spec_if.sv
// Fetch/commit interface of the tournament predictor.
//   ready                 : tables initialised; queries/updates honoured
//   q_valid/q_address     : fetch query (q_valid shifts the speculative GHR)
//   q_take/q_ghr          : prediction and GHR snapshot carried to commit
//   upd_valid/upd_address/upd_take/upd_ghr/upd_mispredict : commit update
// master = fetch/commit side, slave = predictor.
interface tournament_predictor_spec_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned GHR_W  = 10
);
  logic              ready;
  logic              q_valid;
  logic [ADDR_W-1:0] q_address;
  logic              q_take;
  logic [GHR_W-1:0]  q_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_address;
  logic              upd_take;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_mispredict;

  modport master (
    input  ready, q_take, q_ghr,
    output q_valid, q_address, upd_valid, upd_address, upd_take, upd_ghr, upd_mispredict
  );

  modport slave (
    output ready, q_take, q_ghr,
    input  q_valid, q_address, upd_valid, upd_address, upd_take, upd_ghr, upd_mispredict
  );
endinterface

// File: rtl/bp_init_sweeper.sv
// Table-initialisation sequencer. After reset it walks a pointer over
// 2^PTR_W entries, strobing init_we each cycle, then parks in RUN.
//   clk, rst  : clock, asynchronous active-high reset (restarts the sweep)
//   ready     : high while in RUN
//   init_we   : write strobe for the init value into every table
//   init_ptr  : entry being initialised (each table truncates it)
module bp_init_sweeper
  import bp_pkg::*;
#(
  parameter int unsigned PTR_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  output logic             init_we,
  output logic [PTR_W-1:0] init_ptr
);
  localparam int unsigned SWEEP_N = 2 ** PTR_W;

  bp_state_e        state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    init_we   = 1'b0;
    if (state == INIT) begin
      init_we = 1'b1;
      ptr_nxt = ptr + 1'b1;
      if (ptr == PTR_W'(SWEEP_N - 1)) state_nxt = RUN;
    end
  end

  assign ready    = (state == RUN);
  assign init_ptr = ptr;
endmodule

// File: rtl/tournament_predictor_spec.sv
// Tournament branch predictor: per-PC local history -> local PHT, gshare
// global PHT, per-PC selector choosing between them. Speculative GHR is
// shifted by fetch and restored from the commit snapshot on mispredict.
//   clk, rst : clock, asynchronous active-high reset
//   bp       : slave side of tournament_predictor_spec_if (query + update)
// Tables are plain arrays with no reset; they are cleared by the sweeper.
module tournament_predictor_spec
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned LHIST_W = 10,
  parameter int unsigned GHR_W   = 10,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned SEL_W   = 2
) (
  input  logic clk,
  input  logic rst,
  tournament_predictor_spec_if.slave bp
);
  localparam int unsigned PTR_W   = max(max(IDX_W, LHIST_W), GHR_W);
  localparam int unsigned ADDR_LO = max(IDX_W, GHR_W);
  // Weak-global selector start value: 2^(SEL_W-1)-1.
  localparam logic [SEL_W-1:0] SEL_INIT = {1'b0, {(SEL_W-1){1'b1}}};

  logic             ready, init_we;
  logic [PTR_W-1:0] init_ptr;

  bp_init_sweeper #(.PTR_W(PTR_W)) u_sweeper (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .init_we  (init_we),
    .init_ptr (init_ptr)
  );

  logic [LHIST_W-1:0] lht  [2**IDX_W];
  logic [SEL_W-1:0]   sel  [2**IDX_W];
  logic [CTR_W-1:0]   lpht [2**LHIST_W];
  logic [CTR_W-1:0]   gpht [2**GHR_W];
  logic [GHR_W-1:0]   ghr, ghr_nxt;

  // Query path (combinational, pre-update table contents).
  logic [IDX_W-1:0]   pi;
  logic [LHIST_W-1:0] lh;
  logic [GHR_W-1:0]   gi;
  logic               q_pred;

  always_comb begin
    pi     = bp.q_address[IDX_W-1:0];
    lh     = lht[pi];
    gi     = bp.q_address[GHR_W-1:0] ^ ghr;
    q_pred = sel[pi][SEL_W-1] ? lpht[lh][CTR_W-1] : gpht[gi][CTR_W-1];
  end

  assign bp.ready  = ready;
  assign bp.q_take = ready & q_pred;
  assign bp.q_ghr  = ghr;

  // Update path: all reads happen here, before any write lands at the edge.
  logic               u_en, q_en, t;
  logic [IDX_W-1:0]   ui;
  logic [LHIST_W-1:0] ul, lht_new;
  logic [GHR_W-1:0]   ug;
  logic               lp, gp;
  logic [SEL_W-1:0]   sel_new;
  logic [CTR_W-1:0]   lctr_new, gctr_new;

  assign u_en = ready & bp.upd_valid;
  assign q_en = ready & bp.q_valid;
  assign t    = bp.upd_take;

  always_comb begin
    ui      = bp.upd_address[IDX_W-1:0];
    ul      = lht[ui];
    ug      = bp.upd_address[GHR_W-1:0] ^ bp.upd_ghr;
    lp      = lpht[ul][CTR_W-1];
    gp      = gpht[ug][CTR_W-1];
    sel_new = sel[ui];
    if (gp == t && lp != t)      sel_new = SEL_W'(sat_dec(32'(sel[ui])));
    else if (lp == t && gp != t) sel_new = SEL_W'(sat_inc(32'(sel[ui]), SEL_W));
    lctr_new = t ? CTR_W'(sat_inc(32'(lpht[ul]), CTR_W)) : CTR_W'(sat_dec(32'(lpht[ul])));
    gctr_new = t ? CTR_W'(sat_inc(32'(gpht[ug]), CTR_W)) : CTR_W'(sat_dec(32'(gpht[ug])));
    lht_new  = {ul[LHIST_W-2:0], t};
  end

  // One write port per table: sweeper during INIT, commit update in RUN.
  always_ff @(posedge clk) begin
    if (init_we)   lht[init_ptr[IDX_W-1:0]] <= '0;
    else if (u_en) lht[ui] <= lht_new;
  end

  always_ff @(posedge clk) begin
    if (init_we)   sel[init_ptr[IDX_W-1:0]] <= SEL_INIT;
    else if (u_en) sel[ui] <= sel_new;
  end

  always_ff @(posedge clk) begin
    if (init_we)   lpht[init_ptr[LHIST_W-1:0]] <= '0;
    else if (u_en) lpht[ul] <= lctr_new;
  end

  always_ff @(posedge clk) begin
    if (init_we)   gpht[init_ptr[GHR_W-1:0]] <= '0;
    else if (u_en) gpht[ug] <= gctr_new;
  end

  // Mispredict recovery overrides the same-cycle speculative shift.
  always_comb begin
    ghr_nxt = ghr;
    if (u_en && bp.upd_mispredict) ghr_nxt = {bp.upd_ghr[GHR_W-2:0], bp.upd_take};
    else if (q_en)                 ghr_nxt = {ghr[GHR_W-2:0], q_pred};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr <= '0;
    else     ghr <= ghr_nxt;
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^{bp.q_address[ADDR_W-1:ADDR_LO], bp.upd_address[ADDR_W-1:ADDR_LO]};
endmodule

// File: tb/tb_tournament_predictor_spec.sv
// Directed bench for tournament_predictor_spec at default parameters.
module tb_tournament_predictor_spec;
  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  tournament_predictor_spec_if #(.ADDR_W(17), .GHR_W(10)) bp_if ();

  tournament_predictor_spec #(
    .ADDR_W(17), .IDX_W(10), .LHIST_W(10), .GHR_W(10), .CTR_W(2), .SEL_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bp_if.q_valid        = 1'b0;
    bp_if.q_address      = '0;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_address    = '0;
    bp_if.upd_take       = 1'b0;
    bp_if.upd_ghr        = '0;
    bp_if.upd_mispredict = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hammers the inputs during the sweep (they must be ignored) and measures
  // the number of edges until ready rises, bounded at 2000.
  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (bp_if.ready !== 1'b1 && n < 2000) begin
      bp_if.q_valid        = 1'b1;
      bp_if.q_address      = 17'($urandom);
      bp_if.upd_valid      = 1'b1;
      bp_if.upd_address    = 17'($urandom);
      bp_if.upd_take       = 1'b1;
      bp_if.upd_ghr        = 10'($urandom);
      bp_if.upd_mispredict = 1'b1;
      #1;
      if (n == 0 || n == 511 || n == 1023) begin
        chk({tag, "_sweep_q_take"}, 32'(bp_if.q_take), 32'd0);
        chk({tag, "_sweep_q_ghr"}, 32'(bp_if.q_ghr), 32'd0);
      end
      step();
      n++;
    end
    idle();
    chk({tag, "_ready_latency"}, n, 32'd1024);
  endtask

  initial begin
    logic [9:0] qg;
    logic       qt;

    idle();
    rst = 1'b1;
    #12;
    chk("rst_ready", 32'(bp_if.ready), 32'd0);
    chk("rst_q_ghr", 32'(bp_if.q_ghr), 32'd0);
    rst = 1'b0;
    wait_ready("init");

    // Always-taken branch at 0x010 trained through the global side.
    for (int k = 0; k < 13; k++) begin
      bp_if.q_valid   = (k < 12);
      bp_if.q_address = 17'h010;
      #1;
      chk($sformatf("train_q_take_%0d", k), 32'(bp_if.q_take), (k == 12) ? 32'd1 : 32'd0);
      chk($sformatf("train_q_ghr_%0d", k), 32'(bp_if.q_ghr), ((32'd1 << k) - 32'd1) & 32'h3FF);
      qg = bp_if.q_ghr;
      qt = bp_if.q_take;
      step();
      idle();
      if (k < 12) begin
        bp_if.upd_valid      = 1'b1;
        bp_if.upd_address    = 17'h010;
        bp_if.upd_take       = 1'b1;
        bp_if.upd_ghr        = qg;
        bp_if.upd_mispredict = (qt != 1'b1);
        step();
        idle();
      end
    end

    // Recovery to 0x2A5, then recovery colliding with a query shift.
    bp_if.upd_valid      = 1'b1;
    bp_if.upd_address    = 17'h100;
    bp_if.upd_take       = 1'b1;
    bp_if.upd_ghr        = 10'h152;
    bp_if.upd_mispredict = 1'b1;
    step();
    idle();
    #1;
    chk("recover_ghr", 32'(bp_if.q_ghr), 32'h2A5);
    bp_if.q_valid        = 1'b1;
    bp_if.q_address      = 17'h100;
    bp_if.upd_valid      = 1'b1;
    bp_if.upd_address    = 17'h100;
    bp_if.upd_take       = 1'b1;
    bp_if.upd_ghr        = 10'h0F0;
    bp_if.upd_mispredict = 1'b1;
    step();
    idle();
    bp_if.q_address = 17'h100;
    #1;
    chk("collide_ghr", 32'(bp_if.q_ghr), 32'h1E1);
    chk("collide_q_take", 32'(bp_if.q_take), 32'd0);
    bp_if.q_valid = 1'b1;
    step();
    idle();
    #1;
    chk("shift_ghr", 32'(bp_if.q_ghr), 32'h3C2);

    // Async reset while running, then again part-way through the sweep.
    #1;
    rst = 1'b1;
    #1;
    chk("run_rst_ready", 32'(bp_if.ready), 32'd0);
    chk("run_rst_ghr", 32'(bp_if.q_ghr), 32'd0);
    #1;
    rst = 1'b0;
    repeat (500) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("sweep_rst_ready", 32'(bp_if.ready), 32'd0);
    #1;
    rst = 1'b0;
    wait_ready("rerun");

    // 0x020: local side trained taken while global entries stay not-taken;
    // selector reaches local after the 13th update and saturates.
    for (int k = 0; k < 15; k++) begin
      bp_if.q_address      = 17'h020;
      bp_if.upd_valid      = 1'b1;
      bp_if.upd_address    = 17'h020;
      bp_if.upd_take       = 1'b1;
      bp_if.upd_ghr        = 10'(k);
      bp_if.upd_mispredict = 1'b0;
      #1;
      chk($sformatf("sel_q_take_%0d", k), 32'(bp_if.q_take), (k >= 13) ? 32'd1 : 32'd0);
      step();
    end
    idle();
    bp_if.q_address = 17'h020;
    #1;
    chk("sel_saturated_q_take", 32'(bp_if.q_take), 32'd1);

    // 0x030: same-cycle update and query see the pre-update counter.
    bp_if.q_address = 17'h030;
    #1;
    chk("rbw_before", 32'(bp_if.q_take), 32'd0);
    bp_if.upd_valid   = 1'b1;
    bp_if.upd_address = 17'h030;
    bp_if.upd_take    = 1'b1;
    bp_if.upd_ghr     = '0;
    step();
    #1;
    chk("rbw_same_cycle", 32'(bp_if.q_take), 32'd0);
    step();
    idle();
    bp_if.q_address = 17'h030;
    #1;
    chk("rbw_next_cycle", 32'(bp_if.q_take), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
